// File: rtl/sat_guard_ctrl.sv
// sat_guard_ctrl: registered signed narrowing clamp (RI -> RO) with saturation
// supervision. It keeps a lifetime saturation count and a per-window count,
// and has an interlock that forces the output to zero when a window collects
// too many saturations.
// Optional build macro SAT_GUARD_HOLD_EN: in RUN, a saturated sample repeats
// the last non-saturated output instead of driving the rail.
module sat_guard_ctrl #(
    parameter int RI = 15,
    parameter int RO = 14,
    parameter int CW = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enable_i,
    input  logic signed [RI-1:0] in_i,
    input  logic                 in_valid_i,
    output logic signed [RO-1:0] out_o,
    output logic                 out_valid_o,
    output logic                 sat_o,
    output logic                 sat_sticky_o,
    output logic        [CW-1:0] sat_cnt_o,
    input  logic        [CW-1:0] win_len_i,
    input  logic        [CW-1:0] trip_lim_i,
    output logic                 trip_o,
    input  logic                 rearm_i,
    input  logic                 clr_i
);

    localparam logic signed [RO-1:0] POS_RAIL = {1'b0, {(RO-1){1'b1}}};
    localparam logic signed [RO-1:0] NEG_RAIL = {1'b1, {(RO-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        TRIPPED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          sat_pos, sat_neg, sat_now;
    logic [RO-1:0] clamp_val;
    logic [CW-1:0] wcnt_q, wsat_q;
    logic          win_end;
    logic          trip_hit;
    logic          cnt_en;   // this valid RUN sample updates the counters
    logic          win_clr;  // entering RUN: restart the window
    logic [RO-1:0] run_val;

    // Detect over-range: the bits above the output sign must all match the input sign.
    always_comb begin
        sat_pos   = ~in_i[RI-1] &  (|in_i[RI-2:RO-1]);
        sat_neg   =  in_i[RI-1] & ~(&in_i[RI-2:RO-1]);
        sat_now   = sat_pos | sat_neg;
        clamp_val = in_i[RO-1:0];
        if (sat_pos)
            clamp_val = POS_RAIL;
        else if (sat_neg)
            clamp_val = NEG_RAIL;
    end

    // Window bookkeeping: last sample of a window and the trip threshold test.
    // The trip test includes the current sample so limit 1 trips on the first saturation.
    always_comb begin
        win_end  = (win_len_i != '0) && (wcnt_q == win_len_i - CW'(1));
        trip_hit = (trip_lim_i != '0) &&
                   (({1'b0, wsat_q} + (CW+1)'(sat_now)) >= {1'b0, trip_lim_i});
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        win_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                    win_clr = 1'b1;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else begin
                    // clr_i swallows the sample: not counted, cannot trip.
                    cnt_en = in_valid_i & ~clr_i;
                    if (cnt_en && trip_hit)
                        state_d = TRIPPED;
                end
            end
            TRIPPED: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (rearm_i) begin
                    state_d = RUN;
                    win_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SAT_GUARD_HOLD_EN
    logic [RO-1:0] hold_q;

    // Remember the last clean output since RUN entry; saturated samples replay it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            hold_q <= '0;
        else if (win_clr)
            hold_q <= '0;
        else if (state_q == RUN && enable_i && in_valid_i && !sat_now)
            hold_q <= clamp_val;
    end

    always_comb run_val = sat_now ? hold_q : clamp_val;
`else
    always_comb run_val = clamp_val;
`endif

    // Event counters: clr_i has priority over any increment.
    // A window that outgrew a shrunk win_len_i keeps counting and wraps at CW.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sat_cnt_o    <= '0;
            sat_sticky_o <= 1'b0;
            wcnt_q       <= '0;
            wsat_q       <= '0;
        end else if (clr_i) begin
            sat_cnt_o    <= '0;
            sat_sticky_o <= 1'b0;
            wcnt_q       <= '0;
            wsat_q       <= '0;
        end else if (win_clr) begin
            wcnt_q <= '0;
            wsat_q <= '0;
        end else if (cnt_en) begin
            if (sat_now) begin
                sat_sticky_o <= 1'b1;
                if (sat_cnt_o != '1)
                    sat_cnt_o <= sat_cnt_o + CW'(1);
            end
            if (win_end) begin
                wcnt_q <= '0;
                wsat_q <= '0;
            end else begin
                wcnt_q <= wcnt_q + CW'(1);
                if (sat_now && wsat_q != '1)
                    wsat_q <= wsat_q + CW'(1);
            end
        end
    end

    // Registered output stage, one cycle of latency; zero outside RUN.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_o       <= '0;
            out_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else if (!enable_i || state_q == IDLE) begin
            out_o       <= '0;
            out_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else if (state_q == TRIPPED) begin
            out_o       <= '0;
            out_valid_o <= in_valid_i;
            sat_o       <= 1'b0;
        end else begin
            out_valid_o <= in_valid_i;
            sat_o       <= in_valid_i & sat_now;
            if (in_valid_i)
                out_o <= run_val;
        end
    end

    always_comb trip_o = (state_q == TRIPPED);

endmodule
